// File: rtl/alu_param.sv
// Parameterised registered ALU: single-cycle arithmetic, logic, compare and shift
// operations, plus a multi-cycle restoring divider that holds BUSY while it iterates.
module alu_param #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_FUN,
  input  logic             IN_VALID,
  output logic             BUSY,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             OUT_VALID,
  output logic             Arith_Flag,
  output logic             Logic_Flag,
  output logic             CMP_Flag,
  output logic             Shift_Flag,
  output logic             Carry_Flag,
  output logic             Zero_Flag,
  output logic             Div_Err
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic {IDLE, DIV} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] dvs, quo, rem;
  logic [SW-1:0]    count;

  logic             start_div, last_iter;
  logic [WIDTH:0]   rem_shift, diff;
  logic [WIDTH-1:0] rem_step, quo_step;

  logic [SW-1:0]      sh;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod, shl_ext, shr_ext;
  logic [WIDTH-1:0]   res;
  logic               carry;
  logic [3:0]         cls;

  assign BUSY      = (state == DIV);
  assign start_div = IN_VALID && (state == IDLE) && (ALU_FUN == 4'd3) && (B != '0);
  assign last_iter = (state == DIV) && (count == SW'(WIDTH - 1));

  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_div) state_next = DIV;
      DIV:  if (last_iter) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One restoring step: shift in the next dividend bit, keep the difference if it did not go negative.
  always_comb begin
    rem_shift = {rem, quo[WIDTH-1]};
    diff      = rem_shift - {1'b0, dvs};
    if (diff[WIDTH]) begin
      rem_step = rem_shift[WIDTH-1:0];
      quo_step = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_step = diff[WIDTH-1:0];
      quo_step = {quo[WIDTH-2:0], 1'b1};
    end
  end

  assign sh      = B[SW-1:0];
  assign sum     = {1'b0, A} + {1'b0, B};
  assign prod    = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
  assign shl_ext = {{WIDTH{1'b0}}, A} << sh;
  assign shr_ext = {A, {WIDTH{1'b0}}} >> sh;

  // cls is {Arith, Logic, CMP, Shift}; the DIV entry only ever lands for a zero divisor.
  always_comb begin
    res   = '0;
    carry = 1'b0;
    cls   = 4'b0000;
    case (ALU_FUN)
      4'd0:  begin res = sum[WIDTH-1:0];   carry = sum[WIDTH];    cls = 4'b1000; end
      4'd1:  begin res = A - B;            carry = (A < B);       cls = 4'b1000; end
      4'd2:  begin res = prod[WIDTH-1:0];  carry = |prod[2*WIDTH-1:WIDTH]; cls = 4'b1000; end
      4'd3:  begin res = '1;                                      cls = 4'b1000; end
      4'd4:  begin res = A & B;                                   cls = 4'b0100; end
      4'd5:  begin res = A | B;                                   cls = 4'b0100; end
      4'd6:  begin res = ~(A & B);                                cls = 4'b0100; end
      4'd7:  begin res = ~(A | B);                                cls = 4'b0100; end
      4'd8:  begin res = A ^ B;                                   cls = 4'b0100; end
      4'd9:  begin res = ~(A ^ B);                                cls = 4'b0100; end
      4'd10: begin res = (A == B) ? WIDTH'(1) : '0;               cls = 4'b0010; end
      4'd11: begin res = (A > B)  ? WIDTH'(2) : '0;               cls = 4'b0010; end
      4'd12: begin res = (A < B)  ? WIDTH'(3) : '0;               cls = 4'b0010; end
      4'd13: begin res = shr_ext[2*WIDTH-1:WIDTH]; carry = |shr_ext[WIDTH-1:0]; cls = 4'b0001; end
      4'd14: begin res = shl_ext[WIDTH-1:0]; carry = |shl_ext[2*WIDTH-1:WIDTH]; cls = 4'b0001; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      ALU_OUT    <= '0;
      OUT_VALID  <= 1'b0;
      Arith_Flag <= 1'b0;
      Logic_Flag <= 1'b0;
      CMP_Flag   <= 1'b0;
      Shift_Flag <= 1'b0;
      Carry_Flag <= 1'b0;
      Zero_Flag  <= 1'b0;
      Div_Err    <= 1'b0;
      dvs        <= '0;
      quo        <= '0;
      rem        <= '0;
      count      <= '0;
    end else begin
      OUT_VALID <= 1'b0;
      if (state == IDLE) begin
        if (start_div) begin
          dvs   <= B;
          quo   <= A;
          rem   <= '0;
          count <= '0;
        end else if (IN_VALID && ALU_FUN != 4'd15) begin
          ALU_OUT    <= res;
          {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag} <= cls;
          Carry_Flag <= carry;
          Zero_Flag  <= (res == '0);
          Div_Err    <= (ALU_FUN == 4'd3);
          OUT_VALID  <= 1'b1;
        end
      end else begin
        quo   <= quo_step;
        rem   <= rem_step;
        count <= count + 1'b1;
        if (last_iter) begin
          ALU_OUT    <= quo_step;
          {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag} <= 4'b1000;
          Carry_Flag <= 1'b0;
          Zero_Flag  <= (quo_step == '0);
          Div_Err    <= 1'b0;
          OUT_VALID  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_param.sv
// Bench for alu_param (WIDTH=16): directed scenarios then randomized operations,
// each checked against an arithmetic reference model of the opcode rules.
module tb_alu_param;

  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] A, B;
  logic [3:0]   ALU_FUN;
  logic         IN_VALID;
  logic         BUSY;
  logic [W-1:0] ALU_OUT;
  logic         OUT_VALID;
  logic         Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
  logic         Carry_Flag, Zero_Flag, Div_Err;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [W-1:0] exp_out;
  logic [3:0]   exp_cls;
  logic         exp_carry, exp_zero, exp_err;

  alu_param #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN), .IN_VALID(IN_VALID),
    .BUSY(BUSY), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
    .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag),
    .Shift_Flag(Shift_Flag), .Carry_Flag(Carry_Flag), .Zero_Flag(Zero_Flag),
    .Div_Err(Div_Err)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic checkState(input string tag, input logic valid_exp);
    checkOutput({tag, "/out"},   64'(ALU_OUT), 64'(exp_out));
    checkOutput({tag, "/class"}, 64'({Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag}), 64'(exp_cls));
    checkOutput({tag, "/carry"}, 64'(Carry_Flag), 64'(exp_carry));
    checkOutput({tag, "/zero"},  64'(Zero_Flag), 64'(exp_zero));
    checkOutput({tag, "/err"},   64'(Div_Err), 64'(exp_err));
    checkOutput({tag, "/valid"}, 64'(OUT_VALID), 64'(valid_exp));
  endtask

  // Reference model straight from the opcode rules, using wide integer arithmetic.
  task automatic refModel(input logic [3:0] fun, input logic [W-1:0] a_in, input logic [W-1:0] b_in);
    longint a, b, r, m, p;
    int     sh;
    a = longint'(a_in);
    b = longint'(b_in);
    m = longint'(1) << W;
    sh = int'(b % W);
    r = 0;
    exp_carry = 1'b0;
    exp_err   = 1'b0;
    case (fun)
      4'd0: begin r = (a + b) % m; exp_carry = (a + b) >= m; end
      4'd1: begin r = (a - b + m) % m; exp_carry = a < b; end
      4'd2: begin p = a * b; r = p % m; exp_carry = p >= m; end
      4'd3: begin
        if (b == 0) begin r = m - 1; exp_err = 1'b1; end
        else r = a / b;
      end
      4'd4:  r = a & b;
      4'd5:  r = a | b;
      4'd6:  r = (~(a & b)) & (m - 1);
      4'd7:  r = (~(a | b)) & (m - 1);
      4'd8:  r = a ^ b;
      4'd9:  r = (~(a ^ b)) & (m - 1);
      4'd10: r = (a == b) ? 1 : 0;
      4'd11: r = (a > b) ? 2 : 0;
      4'd12: r = (a < b) ? 3 : 0;
      4'd13: begin p = longint'(1) << sh; r = a / p; exp_carry = (a % p) != 0; end
      4'd14: begin p = a * (longint'(1) << sh); r = p % m; exp_carry = p >= m; end
      default: ;
    endcase
    exp_out  = r[W-1:0];
    exp_zero = (r == 0);
    if (fun <= 4'd3)       exp_cls = 4'b1000;
    else if (fun <= 4'd9)  exp_cls = 4'b0100;
    else if (fun <= 4'd12) exp_cls = 4'b0010;
    else                   exp_cls = 4'b0001;
  endtask

  // Issues one request and follows it to its result, scribbling on the inputs while busy.
  task automatic applyStimulus(input logic [3:0] fun, input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                               input string tag);
    int k;
    @(negedge CLK);
    ALU_FUN = fun; A = a_in; B = b_in; IN_VALID = 1'b1;
    @(negedge CLK);
    if (fun == 4'd15) begin
      IN_VALID = 1'b0;
      checkState({tag, "/nop"}, 1'b0);
    end else if (fun == 4'd3 && b_in != '0) begin
      checkOutput({tag, "/busy_start"}, 64'(BUSY), 64'd1);
      checkOutput({tag, "/valid_early"}, 64'(OUT_VALID), 64'd0);
      k = 0;
      while (k < 40 && !OUT_VALID) begin
        ALU_FUN = 4'($urandom_range(0, 15)); A = W'($urandom); B = W'($urandom);
        IN_VALID = 1'b1;
        @(negedge CLK);
        k++;
      end
      IN_VALID = 1'b0;
      checkOutput({tag, "/latency"}, 64'(k), 64'(W));
      refModel(fun, a_in, b_in);
      checkState(tag, 1'b1);
      checkOutput({tag, "/busy_end"}, 64'(BUSY), 64'd0);
    end else begin
      IN_VALID = 1'b0;
      refModel(fun, a_in, b_in);
      checkState(tag, 1'b1);
      checkOutput({tag, "/busy"}, 64'(BUSY), 64'd0);
    end
    @(negedge CLK);
    checkState({tag, "/hold"}, 1'b0);
  endtask

  initial begin
    int pulses;
    logic [3:0]   f;
    logic [W-1:0] ra, rb;

    RST = 1'b0; IN_VALID = 1'b0; ALU_FUN = 4'd0; A = '0; B = '0;
    repeat (2) @(negedge CLK);
    exp_out = '0; exp_cls = 4'b0000; exp_carry = 1'b0; exp_zero = 1'b0; exp_err = 1'b0;
    checkState("reset", 1'b0);
    checkOutput("reset/busy", 64'(BUSY), 64'd0);
    RST = 1'b1;

    applyStimulus(4'd0, 16'd4, 16'd3, "add_4_3");
    applyStimulus(4'd15, 16'd1, 16'd1, "nop_after_add");
    checkOutput("nop_keeps_7", 64'(ALU_OUT), 64'd7);
    applyStimulus(4'd0, 16'hFFFF, 16'd1, "add_wrap");
    applyStimulus(4'd14, 16'd7, 16'd2, "shl_7_2");
    applyStimulus(4'd13, 16'hABCD, 16'd0, "shr_by0");
    applyStimulus(4'd1, 16'd3, 16'd5, "sub_borrow");
    applyStimulus(4'd3, 16'd100, 16'd7, "div_100_7");
    checkOutput("div_100_7/q", 64'(ALU_OUT), 64'd14);

    // Divide by zero must finish in one edge without ever raising BUSY.
    @(negedge CLK);
    ALU_FUN = 4'd3; A = 16'd5; B = 16'd0; IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    refModel(4'd3, 16'd5, 16'd0);
    checkState("div_by0", 1'b1);
    checkOutput("div_by0/busy", 64'(BUSY), 64'd0);

    // Reset in the middle of a divide aborts it silently.
    @(negedge CLK);
    ALU_FUN = 4'd3; A = 16'd100; B = 16'd7; IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    repeat (7) @(negedge CLK);
    checkOutput("abort/busy_before", 64'(BUSY), 64'd1);
    RST = 1'b0; IN_VALID = 1'b1; ALU_FUN = 4'd0;
    @(negedge CLK);
    RST = 1'b1; IN_VALID = 1'b0;
    exp_out = '0; exp_cls = 4'b0000; exp_carry = 1'b0; exp_zero = 1'b0; exp_err = 1'b0;
    checkState("abort", 1'b0);
    checkOutput("abort/busy", 64'(BUSY), 64'd0);
    pulses = 0;
    repeat (20) begin
      @(negedge CLK);
      if (OUT_VALID) pulses++;
    end
    checkOutput("abort/no_pulse", 64'(pulses), 64'd0);
    applyStimulus(4'd10, 16'd9, 16'd9, "eq_9_9");

    for (int i = 0; i < 150; i++) begin
      f  = 4'($urandom_range(0, 15));
      ra = W'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1, 2:    rb = W'($urandom_range(0, 20));
        3:       rb = ra;
        default: rb = W'($urandom);
      endcase
      applyStimulus(f, ra, rb, $sformatf("rand%0d_op%0d", i, f));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/alu_param.md
ALU_PARAM -- requirements
Module: alu_param

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width; legal values 4, 8, 16, 32, 64.
REQ-002 SHALL have localparam SW = clog2(WIDTH), the shift-amount width.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port A, input, WIDTH bits: operand A, unsigned.
REQ-006 SHALL have port B, input, WIDTH bits: operand B, unsigned.
REQ-007 SHALL have port ALU_FUN, input, 4 bits: opcode.
REQ-008 SHALL have port IN_VALID, input, 1 bit: operation request.
REQ-009 SHALL have port BUSY, output, 1 bit: divider in progress; requests are ignored while high.
REQ-010 SHALL have port ALU_OUT, output, WIDTH bits: registered result.
REQ-011 SHALL have port OUT_VALID, output, 1 bit: one-cycle pulse when a new result lands.
REQ-012 SHALL have ports Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag, outputs, 1 bit each: one-hot class of the last result.
REQ-013 SHALL have ports Carry_Flag, Zero_Flag, Div_Err, outputs, 1 bit each: status of the last result.

Function
REQ-014 SHALL accept a request at a rising edge where IN_VALID=1, BUSY=0 and RST=1.
REQ-015 SHALL implement opcodes 0 ADD, 1 SUB, 2 MUL (low WIDTH bits), 3 DIV (quotient), 4 AND, 5 OR, 6 NAND, 7 NOR, 8 XOR, 9 XNOR.
REQ-016 SHALL implement opcodes 10 EQ, 11 GT, 12 LT, with result 1, 2 or 3 respectively when true and 0 when false.
REQ-017 SHALL implement opcode 13 SHR as a logical right shift of A by B[SW-1:0], and opcode 14 SHL as a left shift of A by B[SW-1:0].
REQ-018 SHALL treat opcode 15 NOP as accepted but leave ALU_OUT, all flags and OUT_VALID unchanged (OUT_VALID=0).
REQ-019 SHALL give opcodes 0-2 and 4-14 a latency of 1: ALU_OUT, flags and OUT_VALID=1 are registered at the accepting edge.
REQ-020 SHALL compute DIV with an iterative restoring divider, one quotient bit per cycle, using FSM states IDLE and DIV.
REQ-021 SHALL go IDLE->DIV on DIV acceptance, latching A and B and setting BUSY=1 at that edge.
REQ-022 SHALL go DIV->IDLE after WIDTH iterations, registering the quotient with OUT_VALID=1 and BUSY=0 at edge WIDTH after acceptance.
REQ-023 SHALL, for DIV with B=0, take no iterations: at the accepting edge ALU_OUT=all ones, Div_Err=1, Arith_Flag=1, OUT_VALID=1, BUSY stays 0.
REQ-024 SHALL ignore IN_VALID, A, B and ALU_FUN while BUSY=1; divider operands are held internally.
REQ-025 SHALL set class flags one-hot for every result: Arith for 0-3, Logic for 4-9, CMP for 10-12, Shift for 13-14.
REQ-026 SHALL set Carry_Flag as: ADD carry-out; SUB borrow (A<B); MUL upper product half nonzero; SHR/SHL OR of the bits shifted out; 0 for all other opcodes.
REQ-027 SHALL set Zero_Flag=1 when the new ALU_OUT is 0; Div_Err=0 on every result except divide-by-zero.
REQ-028 SHALL keep ALU_OUT and all flags unchanged on edges with no new result, with OUT_VALID=0.
REQ-029 SHALL let a shift amount of 0 pass A through unchanged with Carry_Flag=0.
REQ-030 SHALL let an ADD/SUB overflow wrap modulo 2^WIDTH.

Reset
REQ-031 SHALL, at an edge with RST=0, clear ALU_OUT, all seven flags, OUT_VALID and BUSY to 0 and put the FSM in IDLE.
REQ-032 SHALL, on reset during DIV, abort the operation with no OUT_VALID pulse; RST dominates IN_VALID.

Verification (WIDTH=16)
REQ-033 SHALL check: RST=0 for 2 edges -> ALU_OUT=0, all flags 0, BUSY=0, OUT_VALID=0.
REQ-034 SHALL check: A=4, B=3, FUN=0, IN_VALID for one cycle -> next edge ALU_OUT=7, {Arith,Logic,CMP,Shift}=4'b1000, Carry=0, OUT_VALID pulse of 1 cycle; then FUN=15 -> ALU_OUT stays 7.
REQ-035 SHALL check: A=16'hFFFF, B=1, ADD -> ALU_OUT=0, Carry=1, Zero=1; then A=7, B=2, SHL -> ALU_OUT=28, Shift_Flag=1, Carry=0.
REQ-036 SHALL check: A=100, B=7, DIV -> BUSY high 16 cycles, ALU_OUT=14 with OUT_VALID at edge 16; an ADD request at cycle 5 is ignored.
REQ-037 SHALL check: A=5, B=0, DIV -> next edge ALU_OUT=16'hFFFF, Div_Err=1, BUSY never 1.
REQ-038 SHALL check: DIV 100/7, RST=0 at cycle 8 -> BUSY=0, ALU_OUT=0, no OUT_VALID; a following EQ with A=B=9 -> ALU_OUT=1, CMP_Flag=1.
